// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/stall unit.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOLD = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam int REG_ZERO = 0;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/hazard_stall_unit_match.sv
// Combinational decode of stall need (0/1/2 cycles) and halt request for the ID instruction.
module hazard_match
  import hazard_stall_unit_pkg::*;
#(
  parameter int NB_REG_ADDR = 5
) (
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_use_rs_id,
  input  logic                   i_use_rt_id,
  input  logic                   i_resolve_id,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  input  logic                   i_we_ex,
  input  logic                   i_memread_ex,
  input  logic [NB_REG_ADDR-1:0] i_rd_mem,
  input  logic                   i_memread_mem,
  input  logic                   i_flush,
  input  logic                   i_halt_id,
  output logic [1:0]             o_need,
  output logic                   o_halt
);

  logic rs_nz, rt_nz;
  logic mex_rs, mex_rt, mmem_rs, mmem_rt;
  logic load_ex, load_mem;

  assign rs_nz   = (i_rs_id != NB_REG_ADDR'(REG_ZERO));
  assign rt_nz   = (i_rt_id != NB_REG_ADDR'(REG_ZERO));
  assign mex_rs  = i_use_rs_id & rs_nz & (i_rs_id == i_rd_ex) & i_we_ex;
  assign mex_rt  = i_use_rt_id & rt_nz & (i_rt_id == i_rd_ex) & i_we_ex;
  assign mmem_rs = i_use_rs_id & rs_nz & (i_rs_id == i_rd_mem) & i_memread_mem;
  assign mmem_rt = i_use_rt_id & rt_nz & (i_rt_id == i_rd_mem) & i_memread_mem;

  assign load_ex  = (mex_rs | mex_rt) & i_memread_ex;
  assign load_mem = mmem_rs | mmem_rt;

  // A squashed instruction can neither stall nor halt; halt outranks hazards.
  always_comb begin
    o_need = NEED_NONE;
    o_halt = 1'b0;
    if (!i_flush) begin
      if (i_halt_id)                     o_halt = 1'b1;
      else if (i_resolve_id && load_ex)  o_need = NEED_TWO;
      else if (load_ex)                  o_need = NEED_ONE;
      else if (i_resolve_id && load_mem) o_need = NEED_ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall sequencer with debug halt freeze and saturating stall counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_use_rs_id,
  input  logic                   i_use_rt_id,
  input  logic                   i_resolve_id,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  input  logic                   i_we_ex,
  input  logic                   i_memread_ex,
  input  logic [NB_REG_ADDR-1:0] i_rd_mem,
  input  logic                   i_memread_mem,
  input  logic                   i_flush,
  input  logic                   i_halt_id,
  input  logic                   i_resume,
  output logic                   o_pc_write,
  output logic                   o_ifid_write,
  output logic                   o_idex_bubble,
  output logic                   o_halted,
  output logic [NB_CNT-1:0]      o_stall_count
);

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] count_q, count_d;
  logic [1:0]        need;
  logic              halt_req;
  logic              stall;

  hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_match (
    .i_rs_id       (i_rs_id),
    .i_rt_id       (i_rt_id),
    .i_use_rs_id   (i_use_rs_id),
    .i_use_rt_id   (i_use_rt_id),
    .i_resolve_id  (i_resolve_id),
    .i_rd_ex       (i_rd_ex),
    .i_we_ex       (i_we_ex),
    .i_memread_ex  (i_memread_ex),
    .i_rd_mem      (i_rd_mem),
    .i_memread_mem (i_memread_mem),
    .i_flush       (i_flush),
    .i_halt_id     (i_halt_id),
    .o_need        (need),
    .o_halt        (halt_req)
  );

  always_comb begin
    state_d       = state_q;
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_idex_bubble = 1'b0;
    stall         = 1'b0;
    if (!i_valid) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            state_d      = ST_HALT;
          end else if (need != NEED_NONE) begin
            stall = 1'b1;
            if (need == NEED_TWO) state_d = ST_HOLD;
          end
        end
        // Second stall cycle is owed regardless of operands, unless the consumer is squashed.
        ST_HOLD: begin
          stall   = !i_flush;
          state_d = ST_RUN;
        end
        ST_HALT: begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_idex_bubble = 1'b1;
          if (i_resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
      if (stall) begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
      end
    end
  end

  assign o_halted      = (state_q == ST_HALT);
  assign o_stall_count = count_q;
  assign count_d       = (stall && (count_q != {NB_CNT{1'b1}})) ? count_q + NB_CNT'(1) : count_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (counter narrowed to 4 bits to reach saturation).
module tb_hazard_stall_unit;

  typedef enum {X_RUN, X_STALL, X_FROZEN, X_HALTING, X_HALTED} expKind_e;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       halt;
    logic [3:0] cnt;
  } expVec_t;

  logic       clock, reset, valid;
  logic [4:0] rsId, rtId, rdEx, rdMem;
  logic       useRs, useRt, resolve, weEx, memreadEx, memreadMem;
  logic       flush, haltId, resume;
  logic       pcWrite, ifidWrite, bubble, halted;
  logic [3:0] stallCount;

  expVec_t    sbQ[$];
  string      tagQ[$];
  logic [3:0] expCount;
  int         vecCount = 0;
  int         errCount = 0;

  hazard_stall_unit #(.NB_REG_ADDR(5), .NB_CNT(4)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_valid       (valid),
    .i_rs_id       (rsId),
    .i_rt_id       (rtId),
    .i_use_rs_id   (useRs),
    .i_use_rt_id   (useRt),
    .i_resolve_id  (resolve),
    .i_rd_ex       (rdEx),
    .i_we_ex       (weEx),
    .i_memread_ex  (memreadEx),
    .i_rd_mem      (rdMem),
    .i_memread_mem (memreadMem),
    .i_flush       (flush),
    .i_halt_id     (haltId),
    .i_resume      (resume),
    .o_pc_write    (pcWrite),
    .o_ifid_write  (ifidWrite),
    .o_idex_bubble (bubble),
    .o_halted      (halted),
    .o_stall_count (stallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    valid = 1'b1; rsId = '0; rtId = '0; useRs = 1'b0; useRt = 1'b0; resolve = 1'b0;
    rdEx = '0; weEx = 1'b0; memreadEx = 1'b0; rdMem = '0; memreadMem = 1'b0;
    flush = 1'b0; haltId = 1'b0; resume = 1'b0;
  endtask

  task automatic exLoad(input logic [4:0] rd);
    rdEx = rd; weEx = 1'b1; memreadEx = 1'b1;
  endtask

  task automatic idRead(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt, input logic res);
    rsId = rs; rtId = rt; useRs = urs; useRt = urt; resolve = res;
  endtask

  // Called just after inputs change on a falling edge; the expectation is compared 2ns later.
  task automatic applyStimulus(input string tag, input expKind_e kind);
    expVec_t e;
    e.cnt = expCount;
    case (kind)
      X_RUN:     begin e.pc = 1; e.ifid = 1; e.bub = 0; e.halt = 0; end
      X_STALL:   begin e.pc = 0; e.ifid = 0; e.bub = 1; e.halt = 0; end
      X_FROZEN:  begin e.pc = 0; e.ifid = 0; e.bub = 0; e.halt = 0; end
      X_HALTING: begin e.pc = 0; e.ifid = 0; e.bub = 0; e.halt = 0; end
      default:   begin e.pc = 0; e.ifid = 0; e.bub = 1; e.halt = 1; end
    endcase
    sbQ.push_back(e);
    tagQ.push_back(tag);
    if (kind == X_STALL && expCount != 4'hF) expCount = expCount + 4'd1;
  endtask

  always @(negedge clock) begin
    #2;
    if (sbQ.size() > 0) begin
      expVec_t e;
      string   t;
      e = sbQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, ".pc"},     32'(pcWrite),    32'(e.pc));
      checkOutput({t, ".ifid"},   32'(ifidWrite),  32'(e.ifid));
      checkOutput({t, ".bubble"}, 32'(bubble),     32'(e.bub));
      checkOutput({t, ".halted"}, 32'(halted),     32'(e.halt));
      checkOutput({t, ".count"},  32'(stallCount), 32'(e.cnt));
    end
  end

  initial begin
    setIdle();
    expCount = '0;
    reset = 1'b0;
    #1;
    checkOutput("rst.pc",     32'(pcWrite),    32'd1);
    checkOutput("rst.count",  32'(stallCount), 32'd0);
    checkOutput("rst.halted", 32'(halted),     32'd0);

    @(negedge clock); reset = 1'b1; applyStimulus("idle", X_RUN);

    // ALU consumer of a load: one bubble, then the load sits in MEM and forwarding covers it
    @(negedge clock); setIdle(); exLoad(5'd5); idRead(5'd5, 5'd0, 1, 0, 0); applyStimulus("alu_lu", X_STALL);
    @(negedge clock); setIdle(); rdMem = 5'd5; memreadMem = 1; idRead(5'd5, 5'd0, 1, 0, 0); applyStimulus("alu_lu_after", X_RUN);
    @(negedge clock); setIdle(); exLoad(5'd7); idRead(5'd0, 5'd7, 0, 1, 0); applyStimulus("alu_lu_rt", X_STALL);
    @(negedge clock); setIdle(); exLoad(5'd7); idRead(5'd0, 5'd7, 0, 0, 0); applyStimulus("rt_unused", X_RUN);

    // jr behind a load in EX: two stall cycles; behind a load in MEM: one
    @(negedge clock); setIdle(); exLoad(5'd8); idRead(5'd8, 5'd0, 1, 0, 1); applyStimulus("jr_ex", X_STALL);
    @(negedge clock); setIdle(); rdMem = 5'd8; memreadMem = 1; idRead(5'd8, 5'd0, 1, 0, 1); applyStimulus("jr_hold", X_STALL);
    @(negedge clock); setIdle(); idRead(5'd8, 5'd0, 1, 0, 1); applyStimulus("jr_done", X_RUN);
    @(negedge clock); setIdle(); rdMem = 5'd8; memreadMem = 1; idRead(5'd8, 5'd0, 1, 0, 1); applyStimulus("jr_mem", X_STALL);
    @(negedge clock); setIdle(); applyStimulus("jr_mem_done", X_RUN);

    // Register zero and non-load producers never stall
    @(negedge clock); setIdle(); exLoad(5'd0); idRead(5'd0, 5'd0, 1, 1, 1); applyStimulus("zero_reg", X_RUN);
    @(negedge clock); setIdle(); rdEx = 5'd5; weEx = 1; idRead(5'd5, 5'd0, 1, 0, 0); applyStimulus("alu_fwd", X_RUN);
    @(negedge clock); setIdle(); rdEx = 5'd5; weEx = 1; idRead(5'd5, 5'd0, 1, 0, 1); applyStimulus("br_alu", X_RUN);
    @(negedge clock); setIdle(); rdMem = 5'd6; memreadMem = 1; idRead(5'd6, 5'd0, 1, 0, 0); applyStimulus("mem_alu", X_RUN);

    // Flush priority
    @(negedge clock); setIdle(); exLoad(5'd9); idRead(5'd9, 5'd0, 1, 0, 1); applyStimulus("fl_enter", X_STALL);
    @(negedge clock); setIdle(); flush = 1; applyStimulus("fl_hold", X_RUN);
    @(negedge clock); setIdle(); applyStimulus("fl_after", X_RUN);
    @(negedge clock); setIdle(); exLoad(5'd5); idRead(5'd5, 5'd0, 1, 0, 0); flush = 1; applyStimulus("fl_run", X_RUN);

    // Halt: flush suppresses it, invalid cycle ignores it, otherwise freeze until resume
    @(negedge clock); setIdle(); haltId = 1; flush = 1; applyStimulus("halt_flushed", X_RUN);
    @(negedge clock); setIdle(); haltId = 1; valid = 0; applyStimulus("halt_invalid", X_FROZEN);
    @(negedge clock); setIdle(); haltId = 1; applyStimulus("halt_enter", X_HALTING);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); setIdle();
      if (i % 2 == 1) begin exLoad(5'd3); idRead(5'd3, 5'd0, 1, 0, 1); end
      if (i == 4) flush = 1;
      applyStimulus($sformatf("halted%0d", i), X_HALTED);
    end
    @(negedge clock); setIdle(); resume = 1; applyStimulus("resume", X_HALTED);
    @(negedge clock); setIdle(); applyStimulus("resumed", X_RUN);

    // i_valid gap in the middle of HOLD
    @(negedge clock); setIdle(); exLoad(5'd4); idRead(5'd0, 5'd4, 0, 1, 1); applyStimulus("gap_enter", X_STALL);
    @(negedge clock); setIdle(); valid = 0; applyStimulus("gap0", X_FROZEN);
    @(negedge clock); setIdle(); valid = 0; flush = 1; applyStimulus("gap1", X_FROZEN);
    @(negedge clock); setIdle(); applyStimulus("gap_hold", X_STALL);
    @(negedge clock); setIdle(); applyStimulus("gap_done", X_RUN);

    // Persistent load-use drives the counter into saturation
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); setIdle(); exLoad(5'd2); idRead(5'd2, 5'd0, 1, 0, 0);
      applyStimulus($sformatf("sat%0d", i), X_STALL);
    end
    @(negedge clock); setIdle(); applyStimulus("sat_idle", X_RUN);

    // Asynchronous reset while in HOLD
    @(negedge clock); setIdle(); exLoad(5'd8); idRead(5'd8, 5'd0, 1, 0, 1); applyStimulus("rst_enter", X_STALL);
    @(negedge clock); setIdle();
    #3;
    reset = 1'b0;
    #1;
    checkOutput("arst.pc",     32'(pcWrite),    32'd1);
    checkOutput("arst.bubble", 32'(bubble),     32'd0);
    checkOutput("arst.count",  32'(stallCount), 32'd0);
    expCount = '0;
    @(negedge clock); setIdle(); reset = 1'b1; applyStimulus("arst_after", X_RUN);
    @(negedge clock); setIdle(); applyStimulus("arst_idle", X_RUN);

    @(negedge clock);
    #5;
    checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
